// File: rtl/fpmul_result_checker.sv
// fpmul_result_checker: delays expected FP products by the UUT latency, compares them against DOUT within a ULP
// tolerance, keeps saturating check/error counters and flags DONE/PASS once the pipeline has drained.
module fpmul_result_checker #(
    parameter int LATENCY = 4,
    parameter int TOL_ULP = 0,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             VIN,
    input  logic [31:0]      EXP,
    input  logic             END_IN,
    input  logic [31:0]      DOUT,
    output logic             MISMATCH,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] CHK_CNT,
    output logic [CNT_W-1:0] FIRST_ERR,
    output logic             DONE,
    output logic             PASS
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic [LATENCY-1:0] dv;
    logic [31:0] de [LATENCY];
    logic [31:0] d, diff;
    logic push, d_nan, z_nan, match, cmp, fail;
    logic [CNT_W-1:0] chk_nxt, err_nxt;

    assign push  = VIN & (state == S_IDLE | state == S_RUN);
    assign d     = de[LATENCY-1];
    assign d_nan = (&d[30:23]) & (|d[22:0]);
    assign z_nan = (&DOUT[30:23]) & (|DOUT[22:0]);
    assign diff  = d[30:0] > DOUT[30:0] ? {1'b0, d[30:0]} - {1'b0, DOUT[30:0]}
                                        : {1'b0, DOUT[30:0]} - {1'b0, d[30:0]};
    // signed-zero and any-NaN equivalence come before the magnitude distance test
    assign match = (d == DOUT) | (d[30:0] == 31'd0 & DOUT[30:0] == 31'd0) | (d_nan & z_nan) |
                   (d[31] == DOUT[31] & ~d_nan & ~z_nan & diff <= 32'(TOL_ULP));
    assign cmp     = dv[LATENCY-1] & (state != S_FIN);
    assign fail    = cmp & ~match;
    assign chk_nxt = cmp & ~&CHK_CNT ? CHK_CNT + ONE : CHK_CNT;
    assign err_nxt = fail & ~&ERR_CNT ? ERR_CNT + ONE : ERR_CNT;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if ((state == S_IDLE | state == S_RUN) & END_IN) begin
            state_nxt = S_DRAIN;
            cnt_nxt   = 5'(LATENCY - 1);
        end else if (state == S_IDLE & VIN) begin
            state_nxt = S_RUN;
        end else if (state == S_DRAIN) begin
            state_nxt = cnt == 5'd0 ? S_FIN : S_DRAIN;
            cnt_nxt   = cnt == 5'd0 ? cnt : cnt - 5'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            dv        <= '0;
            MISMATCH  <= 1'b0;
            ERR_CNT   <= '0;
            CHK_CNT   <= '0;
            FIRST_ERR <= '1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            for (int i = LATENCY - 1; i > 0; i--) dv[i] <= dv[i-1];
            dv[0]    <= push;
            MISMATCH <= fail;
            ERR_CNT  <= err_nxt;
            CHK_CNT  <= chk_nxt;
            if (fail && ERR_CNT == '0) FIRST_ERR <= CHK_CNT;
            DONE <= state_nxt == S_FIN;
            PASS <= state_nxt == S_FIN && err_nxt == '0 && chk_nxt != '0;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = LATENCY - 1; i > 0; i--) de[i] <= de[i-1];
        de[0] <= EXP;
    end
endmodule

// File: tb/tb_fpmul_result_checker.sv
// tb_fpmul_result_checker: three checker instances (exact, 1-ULP tolerant, 4-bit counters) driven together,
// checked against directed vectors and a queue-based reference model every cycle.
module tb_fpmul_result_checker;
    localparam int L = 4;

    typedef struct {
        logic [31:0] e;
        int          due;
    } ent_t;

    typedef struct {
        logic [31:0] e;
        logic [31:0] d;
        bit          f0;
        bit          f1;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b1, vin = 1'b0, end_in = 1'b0;
    logic [31:0] exp_v = '0, dout = '0;
    logic mm0, mm1, mm2, done0, done1, done2, pass0, pass1, pass2;
    logic [15:0] err0, err1, chk0, chk1, first0, first1;
    logic [3:0] err2, chk2, first2;
    logic [31:0] sh [L];
    int checks = 0, failures = 0;
    bit mon = 1'b0;

    always #5 clk = ~clk;

    fpmul_result_checker #(.LATENCY(L), .TOL_ULP(0), .CNT_W(16)) u0 (
        .CLK(clk), .RST_n(rst_n), .VIN(vin), .EXP(exp_v), .END_IN(end_in), .DOUT(dout),
        .MISMATCH(mm0), .ERR_CNT(err0), .CHK_CNT(chk0), .FIRST_ERR(first0), .DONE(done0), .PASS(pass0));
    fpmul_result_checker #(.LATENCY(L), .TOL_ULP(1), .CNT_W(16)) u1 (
        .CLK(clk), .RST_n(rst_n), .VIN(vin), .EXP(exp_v), .END_IN(end_in), .DOUT(dout),
        .MISMATCH(mm1), .ERR_CNT(err1), .CHK_CNT(chk1), .FIRST_ERR(first1), .DONE(done1), .PASS(pass1));
    fpmul_result_checker #(.LATENCY(L), .TOL_ULP(0), .CNT_W(4)) u2 (
        .CLK(clk), .RST_n(rst_n), .VIN(vin), .EXP(exp_v), .END_IN(end_in), .DOUT(dout),
        .MISMATCH(mm2), .ERR_CNT(err2), .CHK_CNT(chk2), .FIRST_ERR(first2), .DONE(done2), .PASS(pass2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic bit fp_match(input logic [31:0] a, input logic [31:0] b, input int tol);
        bit an = a[30:23] == 8'hFF && a[22:0] != 0;
        bit bn = b[30:23] == 8'hFF && b[22:0] != 0;
        longint da = longint'(a[30:0]);
        longint db = longint'(b[30:0]);
        longint df = da > db ? da - db : db - da;
        return a == b || (a[30:0] == 0 && b[30:0] == 0) || (an && bn) ||
               (a[31] == b[31] && !an && !bn && df <= longint'(tol));
    endfunction

    // reference model: pending expectations keyed by the cycle their result is due
    ent_t q[$];
    int c, endc;
    bit ended, m_done;
    bit m_mm [3];
    logic [15:0] m_chk [3], m_err [3], m_first [3];
    int tolv [3] = '{0, 1, 0};
    logic [15:0] maxv [3] = '{16'hFFFF, 16'hFFFF, 16'h000F};

    always @(posedge clk or negedge rst_n) begin : model
        ent_t x;
        bit ok;
        if (!rst_n) begin
            q.delete();
            c = 0;
            ended = 0;
            m_done = 0;
            for (int i = 0; i < 3; i++) begin
                m_chk[i] = 0;
                m_err[i] = 0;
                m_first[i] = maxv[i];
                m_mm[i] = 0;
            end
        end else begin
            c++;
            for (int i = 0; i < 3; i++) m_mm[i] = 0;
            if (q.size() > 0 && q[0].due == c) begin
                x = q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    ok = fp_match(x.e, dout, tolv[i]);
                    if (!ok && m_err[i] == 0) m_first[i] = m_chk[i];
                    if (m_chk[i] != maxv[i]) m_chk[i]++;
                    if (!ok) begin
                        m_mm[i] = 1;
                        if (m_err[i] != maxv[i]) m_err[i]++;
                    end
                end
            end
            if (!ended) begin
                if (vin) q.push_back(ent_t'{exp_v, c + L});
                if (end_in) begin
                    ended = 1;
                    endc = c;
                end
            end
            m_done = ended && c >= endc + L;
        end
    end

    always @(negedge clk) begin : monitor
        logic [15:0] ae [3], ac [3], af [3];
        bit am [3], ad [3], ap [3];
        if (mon) begin
            ae = '{err0, err1, {12'h0, err2}};
            ac = '{chk0, chk1, {12'h0, chk2}};
            af = '{first0, first1, {12'h0, first2}};
            am = '{mm0, mm1, mm2};
            ad = '{done0, done1, done2};
            ap = '{pass0, pass1, pass2};
            for (int i = 0; i < 3; i++) begin
                check($sformatf("mon%0d mismatch", i), 32'(am[i]), 32'(m_mm[i]));
                check($sformatf("mon%0d err_cnt", i), 32'(ae[i]), 32'(m_err[i]));
                check($sformatf("mon%0d chk_cnt", i), 32'(ac[i]), 32'(m_chk[i]));
                check($sformatf("mon%0d first_err", i), 32'(af[i]), 32'(m_first[i]));
                check($sformatf("mon%0d done", i), 32'(ad[i]), 32'(m_done));
                check($sformatf("mon%0d pass", i), 32'(ap[i]),
                      32'(m_done && m_err[i] == 0 && m_chk[i] != 0));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        vin = 1'b0;
        end_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // df is the DOUT value presented L cycles later, aligned with this sample
    task automatic step(input bit v, input logic [31:0] e, input bit en, input logic [31:0] df);
        dout = sh[L-1];
        for (int i = L - 1; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = df;
        vin = v;
        exp_v = e;
        end_in = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'h7FC0_0000;
            4: return 32'h7F7F_FFFF;
            5: return 32'hFF80_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] mutate(input logic [31:0] e);
        case ($urandom_range(0, 6))
            3: return e + 32'd1;
            4: return e - 32'd1;
            5: return e ^ 32'h8000_0000;
            6: return pick();
            default: return e;
        endcase
    endfunction

    initial begin
        vec_t vt [9];
        bit pat [5] = '{1, 0, 1, 1, 0};
        logic [31:0] e;
        for (int i = 0; i < L; i++) sh[i] = '0;
        vt = '{
            '{32'h4110_0000, 32'h4110_0000, 0, 0},
            '{32'h4110_0000, 32'h4110_0001, 1, 0},
            '{32'h0000_0000, 32'h8000_0000, 0, 0},
            '{32'h7FC0_0000, 32'h7F80_0001, 0, 0},
            '{32'h7F80_0000, 32'hFF80_0000, 1, 1},
            '{32'h7F7F_FFFF, 32'h7F80_0000, 1, 0},
            '{32'h3F80_0000, 32'h3F80_0002, 1, 1},
            '{32'hFFC0_0000, 32'h7F80_0000, 1, 1},
            '{32'h3F80_0000, 32'hBF80_0000, 1, 1}
        };
        #1;
        do_reset();
        mon = 1'b1;
        check("reset chk", 32'(chk0), 32'h0);
        check("reset err", 32'(err0), 32'h0);
        check("reset first16", 32'(first0), 32'hFFFF);
        check("reset first4", 32'(first2), 32'hF);
        check("reset done", 32'(done0), 32'h0);
        check("reset pass", 32'(pass0), 32'h0);

        step(1, 32'h4110_0000, 0, 32'h4110_0000);
        step(0, 32'h0, 1, 32'h0);
        idle(3);
        check("basic done early", 32'(done0), 32'h0);
        check("basic chk", 32'(chk0), 32'h1);
        idle(1);
        check("basic done", 32'(done0), 32'h1);
        check("basic pass", 32'(pass0), 32'h1);
        check("basic err", 32'(err0), 32'h0);

        for (int k = 0; k < 9; k++) begin
            do_reset();
            step(1, vt[k].e, 1, vt[k].d);
            idle(4);
            check($sformatf("vec%0d mm tol0", k), 32'(mm0), 32'(vt[k].f0));
            check($sformatf("vec%0d mm tol1", k), 32'(mm1), 32'(vt[k].f1));
            check($sformatf("vec%0d err tol0", k), 32'(err0), 32'(vt[k].f0));
            check($sformatf("vec%0d err tol1", k), 32'(err1), 32'(vt[k].f1));
            check($sformatf("vec%0d chk", k), 32'(chk0), 32'h1);
            check($sformatf("vec%0d pass tol0", k), 32'(pass0), 32'(!vt[k].f0));
            check($sformatf("vec%0d pass tol1", k), 32'(pass1), 32'(!vt[k].f1));
            check($sformatf("vec%0d first", k), 32'(first0), vt[k].f0 ? 32'h0 : 32'hFFFF);
            idle(1);
            check($sformatf("vec%0d mm pulse end", k), 32'(mm0), 32'h0);
        end

        do_reset();
        step(0, 32'h0, 1, 32'h0);
        idle(4);
        check("no-compare done", 32'(done0), 32'h1);
        check("no-compare pass", 32'(pass0), 32'h0);

        do_reset();
        for (int k = 0; k < 100; k++) begin
            e = $urandom;
            step(pat[k % 5], e, 0, e);
        end
        step(0, 32'h0, 1, 32'h0);
        idle(4);
        check("bubbles chk", 32'(chk0), 32'd60);
        check("bubbles err", 32'(err0), 32'h0);
        check("bubbles pass", 32'(pass0), 32'h1);
        check("bubbles chk sat4", 32'(chk2), 32'hF);

        do_reset();
        for (int k = 0; k < 20; k++) begin
            e = 32'h3F80_0000 + 32'(k);
            step(1, e, 0, e ^ 32'h10);
        end
        step(0, 32'h0, 1, 32'h0);
        idle(4);
        check("sat err4", 32'(err2), 32'hF);
        check("sat chk4", 32'(chk2), 32'hF);
        check("sat first4", 32'(first2), 32'h0);
        check("sat err16", 32'(err0), 32'd20);
        check("sat pass", 32'(pass0), 32'h0);

        do_reset();
        for (int k = 0; k < 3; k++) step(1, 32'h3F80_0000, 0, 32'h0);
        do_reset();
        check("midreset chk", 32'(chk0), 32'h0);
        check("midreset first", 32'(first0), 32'hFFFF);
        idle(6);
        check("midreset stale chk", 32'(chk0), 32'h0);
        check("midreset stale err", 32'(err0), 32'h0);

        do_reset();
        for (int k = 0; k < 300; k++) begin
            e = pick();
            step(1'($urandom_range(0, 1)), e, 0, mutate(e));
        end
        e = pick();
        step(1, e, 1, mutate(e));
        idle(6);
        e = pick();
        step(1, e, 1, mutate(e));
        idle(6);
        check("random done", 32'(done0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
